// File: rtl/count_mon_pkg.sv
// Shared types for the count wrap monitor: event codes, FSM states and the event entry layout.
package count_mon_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [2:0] {
    EVT_NONE    = 3'd0,
    EVT_WRAP_UP = 3'd1,
    EVT_WRAP_DN = 3'd2,
    EVT_LOAD    = 3'd3,
    EVT_JUMP    = 3'd4
  } evt_code_e;

  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef struct packed {
    evt_code_e            code;
    logic [COUNT_W-1:0]   val;
  } evt_entry_t;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO; push is written at the same edge, dout reads registered storage at the head (0 when empty).
// Push into a full FIFO is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// Classifies counter transitions into a valid/ready event FIFO (event visible the edge it is seen) plus wrap/overflow status.
// Define COUNT_WRAP_MON_DIR_CHECK_EN to turn steps and wraps against the sampled direction into JUMP events.
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH      = COUNT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  up_down_i,
  input  logic                  load_i,
  input  logic                  clr_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [2:0]            evt_code_o,
  output logic [WIDTH-1:0]      evt_val_o,
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
  output logic                  overflow_o
);

  localparam int DW = WIDTH + 3;
  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  load_q, load_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                  overflow_q, overflow_d;

  evt_code_e             raw_code, evt_code;
  logic                  seen_up, seen_dn, dir_bad, wrap_hit;
  logic                  push, pop, full, empty;
  logic [DW-1:0]         dout;

`ifdef COUNT_WRAP_MON_DIR_CHECK_EN
  logic dir_q, dir_d;
  assign dir_d   = up_down_i;
  assign dir_bad = (seen_up && !dir_q) || (seen_dn && dir_q);
  always_ff @(posedge clk) begin
    if (reset) dir_q <= 1'b0;
    else       dir_q <= dir_d;
  end
`else
  logic unused_dir;
  assign unused_dir = ^{up_down_i, seen_up, seen_dn};
  assign dir_bad    = 1'b0;
`endif

  // seen_up/seen_dn mark direction-bearing transitions (steps and wraps) for the optional check.
  always_comb begin
    raw_code = EVT_NONE;
    seen_up  = 1'b0;
    seen_dn  = 1'b0;
    if (state_q == TRACK) begin
      if (load_q) begin
        raw_code = EVT_LOAD;
      end else if (count_i != prev_q) begin
        if (prev_q == MAXV && count_i == '0) begin
          raw_code = EVT_WRAP_UP;
          seen_up  = 1'b1;
        end else if (prev_q == '0 && count_i == MAXV) begin
          raw_code = EVT_WRAP_DN;
          seen_dn  = 1'b1;
        end else if (count_i == prev_q + ONE) begin
          seen_up  = 1'b1;
        end else if (count_i == prev_q - ONE) begin
          seen_dn  = 1'b1;
        end else begin
          raw_code = EVT_JUMP;
        end
      end
    end
  end

  assign evt_code = dir_bad ? EVT_JUMP : raw_code;
  assign wrap_hit = (evt_code == EVT_WRAP_UP) || (evt_code == EVT_WRAP_DN);
  assign push     = (evt_code != EVT_NONE);
  assign pop      = evt_ready_i && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = PRIME;
    endcase
    prev_d = count_i;
    load_d = load_i;
  end

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    overflow_d = overflow_q;
    if (wrap_hit && wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
    if (push && full && !pop)         overflow_d = 1'b1;
    if (clr_i) begin
      wrap_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PRIME;
      prev_q     <= '0;
      load_q     <= 1'b0;
      wrap_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      load_q     <= load_d;
      wrap_cnt_q <= wrap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({evt_code, count_i}),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid_o = !empty;
  assign evt_code_o  = dout[DW-1 -: 3];
  assign evt_val_o   = dout[WIDTH-1:0];
  assign wrap_cnt_o  = wrap_cnt_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: vector table, directed FIFO/saturation sequences and random traffic against a queue model.
// Honours COUNT_WRAP_MON_DIR_CHECK_EN in both the model and the direction test.
module tb_count_wrap_monitor;

  localparam int W     = 4;
  localparam int MAXV  = (1 << W) - 1;
  localparam int DEPTH = 4;
  localparam int WMAX  = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] count_i = '0;
  logic         up_down_i = 1'b1;
  logic         load_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         evt_ready_i = 1'b1;
  logic         evt_valid_o;
  logic [2:0]   evt_code_o;
  logic [W-1:0] evt_val_o;
  logic [7:0]   wrap_cnt_o;
  logic         overflow_o;

  count_wrap_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .count_i     (count_i),
    .up_down_i   (up_down_i),
    .load_i      (load_i),
    .clr_i       (clr_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_code_o  (evt_code_o),
    .evt_val_o   (evt_val_o),
    .wrap_cnt_o  (wrap_cnt_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  // Reference model: event queue, counters and the previous sample.
  int m_code[$];
  int m_val[$];
  int m_wc = 0;
  bit m_ov = 1'b0;
  bit m_primed = 1'b0;
  int m_prev = 0;
  bit m_ldq = 1'b0;
  bit m_dirq = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int classify(input int p, input int c, input bit lq, input bit dq);
    int up_diff;
    int dn_diff;
    int code;
    bit going_up;
    bit directional;
    up_diff = (c - p) & MAXV;
    dn_diff = (p - c) & MAXV;
    code = 0;
    going_up = 1'b0;
    directional = 1'b0;
    if (lq) return 3;
    if (c == p) return 0;
    if (p == MAXV && c == 0) begin code = 1; going_up = 1'b1; directional = 1'b1; end
    else if (p == 0 && c == MAXV) begin code = 2; directional = 1'b1; end
    else if (up_diff == 1) begin going_up = 1'b1; directional = 1'b1; end
    else if (dn_diff == 1) begin directional = 1'b1; end
    else code = 4;
`ifdef COUNT_WRAP_MON_DIR_CHECK_EN
    if (directional && going_up != dq) code = 4;
`else
    if (directional && dq) code = code;
`endif
    return code;
  endfunction

  task automatic model(input int c, input bit ud, input bit ld, input bit rdy,
                       input bit clr, input bit rst);
    int code;
    if (rst) begin
      m_code.delete();
      m_val.delete();
      m_wc = 0;
      m_ov = 1'b0;
      m_primed = 1'b0;
      return;
    end
    code = m_primed ? classify(m_prev, c, m_ldq, m_dirq) : 0;
    if (m_code.size() > 0 && rdy) begin
      void'(m_code.pop_front());
      void'(m_val.pop_front());
    end
    if (code != 0) begin
      if (m_code.size() < DEPTH) begin
        m_code.push_back(code);
        m_val.push_back(c);
      end else begin
        m_ov = 1'b1;
      end
    end
    if ((code == 1 || code == 2) && m_wc < WMAX) m_wc++;
    if (clr) begin
      m_wc = 0;
      m_ov = 1'b0;
    end
    m_prev = c;
    m_ldq = ld;
    m_dirq = ud;
    m_primed = 1'b1;
  endtask

  task automatic step(input int c, input bit ud, input bit ld, input bit rdy,
                      input bit clr, input bit rst);
    @(negedge clk);
    count_i     = W'(c);
    up_down_i   = ud;
    load_i      = ld;
    evt_ready_i = rdy;
    clr_i       = clr;
    reset       = rst;
    model(c, ud, ld, rdy, clr, rst);
    cur = c;
    @(posedge clk);
    #1;
    chk("model_valid", int'(evt_valid_o), int'(m_code.size() > 0));
    chk("model_code", int'(evt_code_o), (m_code.size() > 0) ? m_code[0] : 0);
    chk("model_val", int'(evt_val_o), (m_val.size() > 0) ? m_val[0] : 0);
    chk("model_wrap_cnt", int'(wrap_cnt_o), m_wc);
    chk("model_overflow", int'(overflow_o), int'(m_ov));
  endtask

  typedef struct {
    bit rst; int cnt; bit ud; bit ld; bit rdy; bit clr;
    bit e_vld; int e_code; int e_val; int e_wc; bit e_ov;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst cnt ud ld rdy clr | vld code val wc ov
    tbl[0]  = '{1, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[5]  = '{0, 5, 1, 0, 1, 0,  1, 3, 5, 0, 0};
    tbl[6]  = '{0, 5, 1, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[7]  = '{0, 13, 1, 0, 1, 0, 1, 3, 13, 0, 0};
    tbl[8]  = '{0, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 15, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0};
    tbl[13] = '{0, 15, 0, 0, 1, 0, 1, 2, 15, 2, 0};
    tbl[14] = '{0, 14, 0, 1, 1, 0, 0, 0, 0, 2, 0};
    tbl[15] = '{0, 3, 1, 0, 1, 0,  1, 3, 3, 2, 0};
    tbl[16] = '{0, 9, 1, 0, 1, 0,  1, 4, 9, 2, 0};
    tbl[17] = '{0, 9, 1, 0, 1, 1,  0, 0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].cnt, tbl[i].ud, tbl[i].ld, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
      chk($sformatf("vec%0d_valid", i), int'(evt_valid_o), int'(tbl[i].e_vld));
      chk($sformatf("vec%0d_code", i), int'(evt_code_o), tbl[i].e_code);
      chk($sformatf("vec%0d_val", i), int'(evt_val_o), tbl[i].e_val);
      chk($sformatf("vec%0d_wrap_cnt", i), int'(wrap_cnt_o), tbl[i].e_wc);
      chk($sformatf("vec%0d_overflow", i), int'(overflow_o), int'(tbl[i].e_ov));
    end

    // Direction test: 6 -> 5 while the counter was told to count up.
    step(cur, 1, 1, 1, 0, 0);
    step(6, 1, 0, 1, 0, 0);
    step(5, 1, 0, 1, 0, 0);
`ifdef COUNT_WRAP_MON_DIR_CHECK_EN
    chk("dir_jump_valid", int'(evt_valid_o), 1);
    chk("dir_jump_code", int'(evt_code_o), 4);
    chk("dir_jump_val", int'(evt_val_o), 5);
`else
    chk("dir_ignored_valid", int'(evt_valid_o), 0);
`endif
    step(5, 1, 0, 1, 0, 0);

    // Fill with six wraps while the consumer stalls.
    step(cur, 1, 1, 1, 1, 0);
    step(15, 1, 0, 1, 0, 0);
    step(15, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      int v;
      v = (i % 2 == 0) ? 0 : 15;
      step(v, v == 15, 0, 0, 0, 0);
    end
    chk("full_overflow", int'(overflow_o), 1);
    chk("full_wrap_cnt", int'(wrap_cnt_o), 6);
    chk("full_head_code", int'(evt_code_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_code", i), int'(evt_code_o), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("drain%0d_val", i), int'(evt_val_o), (i % 2 == 0) ? 0 : 15);
      step(15, 1, 0, 1, i == 0, 0);
    end
    chk("drained_valid", int'(evt_valid_o), 0);
    chk("drained_overflow", int'(overflow_o), 0);

    // Refill, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (i % 2 == 0) ? 0 : 15;
      step(v, v == 15, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("pushpop_overflow", int'(overflow_o), 0);
    chk("pushpop_wrap_cnt", int'(wrap_cnt_o), 5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pushpop%0d_code", i), int'(evt_code_o), (i % 2 == 0) ? 2 : 1);
      step(0, 0, 0, 1, 0, 0);
    end
    chk("pushpop_empty", int'(evt_valid_o), 0);

    // Saturation, clear, then reset with events still queued.
    for (int i = 0; i < 300; i++) begin
      int v;
      v = (i % 2 == 0) ? 15 : 0;
      step(v, v == 15, 0, 0, 0, 0);
    end
    chk("sat_wrap_cnt", int'(wrap_cnt_o), 255);
    chk("sat_overflow", int'(overflow_o), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_wrap_cnt", int'(wrap_cnt_o), 0);
    chk("clr_overflow", int'(overflow_o), 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pre_reset_valid", int'(evt_valid_o), 1);
    step(0, 1, 0, 0, 0, 1);
    chk("reset_valid", int'(evt_valid_o), 0);
    chk("reset_code", int'(evt_code_o), 0);
    step(7, 1, 0, 1, 0, 0);
    chk("prime_no_event", int'(evt_valid_o), 0);
    step(8, 1, 0, 1, 0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int r, nxt;
      r = $urandom_range(0, 9);
      if (r < 3)       nxt = (cur + 1) & MAXV;
      else if (r < 6)  nxt = (cur - 1) & MAXV;
      else if (r < 7)  nxt = cur;
      else if (r < 8)  nxt = $urandom_range(0, MAXV);
      else             nxt = (cur == MAXV) ? 0 : ((cur == 0) ? MAXV : cur);
      step(nxt, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Downstream consumer of the self-reloading up/down counter. Samples the counter's `count` output every cycle, together with the `up_down` and `load_i` controls that produced it.
- Classifies each count transition and queues the interesting ones (wrap-up, wrap-down, load, illegal jump) in a small event FIFO with a valid/ready interface.
- Also keeps a saturating wrap counter and a sticky overflow flag for status readback.

Parameters:
- WIDTH, 4, counter width; must match the counter's `count` width.
- FIFO_DEPTH, 4, number of event entries; power of two, at least 2.
- WRAP_CNT_W, 8, width of the saturating wrap counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- count_i  in  WIDTH  counter output (the counter's `count`).
- up_down_i  in  1  direction control driven to the counter (1 = up, 0 = down).
- load_i  in  1  load strobe driven to the counter.
- clr_i  in  1  synchronous clear of wrap_cnt_o and overflow_o; does not touch the FIFO.
- evt_valid_o  out  1  FIFO head holds a valid event.
- evt_ready_i  in  1  consumer accepts the head event this cycle.
- evt_code_o  out  3  head event code.
- evt_val_o  out  WIDTH  count value captured with the head event.
- wrap_cnt_o  out  WRAP_CNT_W  saturating count of wrap-up plus wrap-down events.
- overflow_o  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset values: evt_valid_o=0, evt_code_o=0, evt_val_o=0, wrap_cnt_o=0, overflow_o=0. FIFO is emptied and the FSM returns to PRIME.
- FSM states:
  - PRIME: after reset, capture prev_q<=count_i, load_q<=load_i, dir_q<=up_down_i. Emit no event. Go to TRACK next cycle.
  - TRACK: compare count_i against prev_q every cycle, then update prev_q, load_q and dir_q.
- Classification in TRACK, first match wins:
  - load_q=1 -> LOAD (code 3). Any value is legal, including unchanged.
  - count_i==prev_q -> HOLD. Not queued.
  - prev_q=max and count_i=0 -> WRAP_UP (code 1).
  - prev_q=0 and count_i=max -> WRAP_DN (code 2).
  - count_i==prev_q+1 or prev_q-1 (non-wrapping) -> STEP. Not queued.
  - anything else -> JUMP (code 4).
  - Code 0 is never emitted.
- Latency: a transition seen at rising edge t is written into the FIFO at edge t. With the FIFO empty, evt_valid_o is high from edge t onward.
- Pushed entry: {code, count_i}.
- FIFO handshake:
  - A pop occurs when evt_valid_o && evt_ready_i at a rising edge.
  - Outputs come from registered storage at the head pointer and are stable while valid && !ready.
  - When empty, evt_code_o and evt_val_o read 0.
- Full FIFO:
  - Push without pop: the event is dropped and overflow_o sets.
  - Push and pop in the same cycle: both occur and nothing is dropped.
- Empty FIFO: pop is ignored and evt_ready_i is don't-care.
- wrap_cnt_o increments on every WRAP_UP or WRAP_DN, even if that event is dropped, and saturates at all-ones.
- clr_i:
  - Zeroes wrap_cnt_o and overflow_o.
  - If clr_i coincides with an increment or an overflow set, clr_i wins.
- Reset mid-operation: returns to PRIME. Queued events are lost and the first post-reset sample is never classified.

Optional Feature:
- Macro: COUNT_WRAP_MON_DIR_CHECK_EN.
- Defined: a STEP, WRAP_UP or WRAP_DN whose direction disagrees with dir_q is reclassified as JUMP (code 4). Example: dir_q=1 with prev_q=5, count_i=4 -> JUMP. wrap_cnt_o does not increment for a reclassified wrap.
- Undefined: dir_q is unused and any ±1 or wrap transition is accepted regardless of up_down_i.

Decomposition:
- Package count_mon_pkg:
  - typedef enum logic [2:0] evt_code_e: EVT_NONE=0, EVT_WRAP_UP=1, EVT_WRAP_DN=2, EVT_LOAD=3, EVT_JUMP=4.
  - typedef enum state_e: PRIME, TRACK.
  - Entry struct {evt_code_e code; logic [WIDTH-1:0] val}, with WIDTH taken from a package constant COUNT_W=4.
- Sub-module event_fifo: parameterised depth and data width, synchronous reset. Ports push, pop, din, dout, full, empty.
- Top level holds the FSM, the classifier and the status counters.

Test Plan:
- Load: reset 3 cycles; load_i=1 with the counter loaded to 5 -> exactly one LOAD event, val=5. No event in the PRIME cycle. evt_valid_o high one edge after count_i reaches 5.
- Up-count wrap: count 13,14,15,0,1 with up_down=1 and evt_ready_i=1 -> one WRAP_UP, val=0; wrap_cnt_o=1; no STEP events queued.
- Down-count wrap: count 1,0,15,14 with up_down=0 -> one WRAP_DN, val=15; wrap_cnt_o increments by 1.
- Illegal jump: count_i forced 3 -> 9 with load_i=0 -> JUMP, val=9.
  - With COUNT_WRAP_MON_DIR_CHECK_EN defined: up_down=1 and count 6 -> 5 -> JUMP, val=5.
- FIFO full: evt_ready_i=0 for 6 wraps -> 4 entries held, overflow_o=1, wrap_cnt_o=6.
  - Then evt_ready_i=1: the 4 entries drain in order.
  - Then a push and pop in the same cycle while full -> nothing lost.
- Saturation and clear: run 300 wraps -> wrap_cnt_o=255.
  - Pulse clr_i -> wrap_cnt_o=0 and overflow_o=0.
  - Assert reset mid-stream with 2 events queued -> evt_valid_o=0 next cycle.
